// File: rtl/stack_unit_pkg.sv
// stack_unit_pkg: shared types for the LIFO stack unit.
//   op_e      - per-cycle operation decoded from the push/pop strobes
//   decode_op - maps {push, pop} onto op_e
package stack_unit_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11   // push and pop together: replace-top or pass-through
    } op_e;

    function automatic op_e decode_op(input logic push, input logic pop);
        op_e op;
        case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_SWAP;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stack_unit_ram.sv
// stack_ram: storage array for stack_unit.
//   clk   - write clock
//   we    - write enable; wdata is stored at waddr on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - asynchronous read address
//   rdata - mem[raddr], combinational
// Contents are not reset.
module stack_ram
    import stack_unit_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_unit.sv
// stack_unit: hardware LIFO for CALL/RET and PUSH/POP storage.
//   clk, reset      - clock; synchronous active-high reset
//   clear           - synchronous flush (pointer, dout, error flags)
//   push, pop, din  - stack operations; both together replace the top
//   dout            - registered, last popped (or passed-through) word
//   count           - valid entries, 0..DEPTH
//   empty, full     - decoded from the pointer
//   overflow        - sticky: push rejected while full
//   underflow       - sticky: pop rejected while empty
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  DEPTH   = 2 ** DEPTH_LOG2;
    localparam int                  SP_W    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] SP_ONE  = SP_W'(1);
    localparam logic [DEPTH_LOG2:0] SP_FULL = SP_W'(DEPTH);

    logic [DEPTH_LOG2:0]   sp_q, sp_d, sp_m1;
    logic [WIDTH-1:0]      dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  we;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [WIDTH-1:0]      rdata;

    // Top of stack lives at sp-1; the read port always looks there so a
    // pop or replace-top picks up the old top before the write edge.
    assign sp_m1 = sp_q - SP_ONE;

    stack_ram #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (din),
        .raddr (sp_m1[DEPTH_LOG2-1:0]),
        .rdata (rdata)
    );

    assign empty     = (sp_q == '0);
    assign full      = (sp_q == SP_FULL);
    assign count     = sp_q;
    assign dout      = dout_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    always_comb begin
        sp_d   = sp_q;
        dout_d = dout_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        we     = 1'b0;
        waddr  = sp_q[DEPTH_LOG2-1:0];

        // Reset shares this path so a push in the same cycle never writes mem.
        if (reset || clear) begin
            sp_d   = '0;
            dout_d = '0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end else begin
            case (decode_op(push, pop))
                OP_PUSH: begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        we   = 1'b1;
                        sp_d = sp_q + SP_ONE;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        dout_d = rdata;
                        sp_d   = sp_m1;
                    end
                end
                OP_SWAP: begin
                    if (empty) begin
                        dout_d = din;          // pass-through, nothing stored
                    end else begin
                        dout_d = rdata;        // old top out, new top in place
                        we     = 1'b1;
                        waddr  = sp_m1[DEPTH_LOG2-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        sp_q   <= sp_d;
        dout_q <= dout_d;
        ovf_q  <= ovf_d;
        unf_q  <= unf_d;
    end

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

    localparam int W  = 8;
    localparam int DL = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          reset, clear, push, pop;
    logic [W-1:0]  din, dout;
    logic [DL:0]   count;
    logic          empty, full, overflow, underflow;

    int tests = 0;
    int fails = 0;

    // Behavioural model: queue with back = top of stack.
    logic [W-1:0] stk[$];
    logic [W-1:0] m_dout;
    logic         m_ovf, m_unf;
    logic         chk_en = 1'b0;

    always #5 clk = ~clk;

    stack_unit #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .dout      (dout),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic c, input logic ps,
                              input logic pp, input logic [W-1:0] d);
        if (r || c) begin
            stk.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else if (ps && pp) begin
            if (stk.size() == 0) m_dout = d;
            else begin
                m_dout = stk[stk.size()-1];
                stk[stk.size()-1] = d;
            end
        end else if (ps) begin
            if (stk.size() == D) m_ovf = 1'b1;
            else stk.push_back(d);
        end else if (pp) begin
            if (stk.size() == 0) m_unf = 1'b1;
            else m_dout = stk.pop_back();
        end
    endtask

    // One clock cycle with the given inputs; model advances on the same edge.
    task automatic step(input logic r, input logic c, input logic ps,
                        input logic pp, input logic [W-1:0] d);
        reset = r; clear = c; push = ps; pop = pp; din = d;
        @(posedge clk);
        model_step(r, c, ps, pp, d);
        chk_en = 1'b1;
        #1;
        reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    // Compare every cycle, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_count", 32'(count), 32'(stk.size()));
            check("m_empty", 32'(empty), 32'(stk.size() == 0));
            check("m_full",  32'(full),  32'(stk.size() == D));
            check("m_dout",  32'(dout),  32'(m_dout));
            check("m_ovf",   32'(overflow),  32'(m_ovf));
            check("m_unf",   32'(underflow), 32'(m_unf));
        end
    end

    initial begin
        reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, 0, 8'h00);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full), 0);
        check("rst_dout",  32'(dout), 0);
        check("rst_ovf",   32'(overflow), 0);
        check("rst_unf",   32'(underflow), 0);

        // LIFO order
        step(0, 0, 1, 0, 8'h11);
        step(0, 0, 1, 0, 8'h22);
        step(0, 0, 1, 0, 8'h33);
        check("lifo_cnt3", 32'(count), 3);
        step(0, 0, 0, 1, 8'h00);
        check("lifo_pop1", 32'(dout), 32'h33);
        step(0, 0, 0, 1, 8'h00);
        check("lifo_pop2", 32'(dout), 32'h22);
        step(0, 0, 0, 1, 8'h00);
        check("lifo_pop3", 32'(dout), 32'h11);
        check("lifo_cnt0", 32'(count), 0);
        check("lifo_empty", 32'(empty), 1);

        // Fill to DEPTH, then overflow
        for (int k = 0; k < D; k++) step(0, 0, 1, 0, 8'(8'h40 + k));
        check("fill_full", 32'(full), 1);
        check("fill_cnt",  32'(count), 16);
        step(0, 0, 1, 0, 8'hAA);
        check("ovf_cnt",  32'(count), 16);
        check("ovf_flag", 32'(overflow), 1);
        step(0, 0, 0, 1, 8'h00);
        check("ovf_pop",  32'(dout), 32'h4F);
        check("ovf_sticky", 32'(overflow), 1);
        // Drain to empty while popping at full rate
        for (int k = 0; k < D - 1; k++) step(0, 0, 0, 1, 8'h00);
        check("drain_dout", 32'(dout), 32'h40);

        // Underflow holds dout, clear flushes
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'h5A);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        check("unf_flag", 32'(underflow), 1);
        check("unf_dout", 32'(dout), 32'h5A);
        step(0, 1, 0, 0, 8'h00);
        check("clr_unf",  32'(underflow), 0);
        check("clr_dout", 32'(dout), 0);

        // Replace-top and pass-through
        step(0, 0, 1, 0, 8'h05);
        step(0, 0, 1, 1, 8'h09);
        check("swap_dout", 32'(dout), 32'h05);
        check("swap_cnt",  32'(count), 1);
        step(0, 0, 0, 1, 8'h00);
        check("swap_pop",  32'(dout), 32'h09);
        step(0, 0, 1, 1, 8'h7E);
        check("pass_dout", 32'(dout), 32'h7E);
        check("pass_cnt",  32'(count), 0);
        check("pass_ovf",  32'(overflow), 0);
        check("pass_unf",  32'(underflow), 0);

        // Replace-top while full: no overflow
        for (int k = 0; k < D; k++) step(0, 0, 1, 0, 8'(8'h80 + k));
        step(0, 0, 1, 1, 8'hEE);
        check("swapf_dout", 32'(dout), 32'h8F);
        check("swapf_ovf",  32'(overflow), 0);
        step(0, 0, 0, 1, 8'h00);
        check("swapf_pop",  32'(dout), 32'hEE);

        // Reset with a concurrent push
        step(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 8'(8'h20 + k));
        check("pre_rst_cnt", 32'(count), 5);
        step(1, 0, 1, 0, 8'hCC);
        check("rstp_cnt",  32'(count), 0);
        check("rstp_dout", 32'(dout), 0);
        check("rstp_flag", 32'({overflow, underflow}), 0);
        step(0, 0, 0, 1, 8'h00);
        check("rstp_unf",  32'(underflow), 1);

        // Clear with a concurrent push is discarded too
        step(0, 0, 1, 0, 8'h31);
        step(0, 1, 1, 0, 8'h32);
        check("clrp_cnt", 32'(count), 0);
        step(0, 0, 0, 0, 8'h00);
        check("idle_cnt", 32'(count), 0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
